tcu_uop_sequencer: RTL and testbench



---
 rtl/tcu_uop_sequencer.sv | 171 +++++++++++++++++
 tb/tb_tcu_uop_sequencer.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/tcu_uop_sequencer.sv
// Expands one WMMA instruction into M*N*K tensor-core micro-ops.
// Optional perf counters are enabled with TCU_UOP_PERF_EN.
module tcu_uop_sequencer #(
    parameter int M_STEPS = 4,
    parameter int N_STEPS = 2,
    parameter int K_STEPS = 2,
    parameter int RA      = 0,
    parameter int RB      = 28,
    parameter int RC      = 10,
    parameter int WID_W   = 2,
    parameter int TAG_W   = 8,
    localparam int MW = (M_STEPS > 1) ? $clog2(M_STEPS) : 1,
    localparam int NW = (N_STEPS > 1) ? $clog2(N_STEPS) : 1,
    localparam int KW = (K_STEPS > 1) ? $clog2(K_STEPS) : 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WID_W-1:0] in_wid,
    input  logic [3:0]       in_fmt_s,
    input  logic [3:0]       in_fmt_d,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WID_W-1:0] out_wid,
    output logic [3:0]       out_fmt_s,
    output logic [3:0]       out_fmt_d,
    output logic [TAG_W-1:0] out_tag,
    output logic [MW-1:0]    out_step_m,
    output logic [NW-1:0]    out_step_n,
    output logic [KW-1:0]    out_step_k,
    output logic [4:0]       out_rs1,
    output logic [4:0]       out_rs2,
    output logic [4:0]       out_rd,
    output logic             out_first,
    output logic             out_last,
    output logic             busy
`ifdef TCU_UOP_PERF_EN
    ,
    output logic [31:0]      perf_instrs,
    output logic [31:0]      perf_stalls
`endif
);

    typedef enum logic [0:0] {IDLE, ISSUE} state_t;

    state_t state_q, state_n;
    logic [MW-1:0] m_n;
    logic [NW-1:0] n_n;
    logic [KW-1:0] k_n;
    logic cap, load;
    logic [4:0] rs1_n, rs2_n, rd_n;
    logic first_n, last_n;

    assign out_valid = (state_q == ISSUE);
    assign busy      = (state_q == ISSUE);

    always_comb begin
        state_n  = state_q;
        m_n      = out_step_m;
        n_n      = out_step_n;
        k_n      = out_step_k;
        cap      = 1'b0;
        load     = 1'b0;
        in_ready = 1'b0;
        unique case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    cap     = 1'b1;
                    load    = 1'b1;
                    m_n     = '0;
                    n_n     = '0;
                    k_n     = '0;
                    state_n = ISSUE;
                end
            end
            ISSUE: begin
                in_ready = out_ready && out_last;
                if (out_ready) begin
                    if (out_last) begin
                        if (in_valid) begin
                            // Back-to-back: next instruction starts without a bubble
                            cap  = 1'b1;
                            load = 1'b1;
                            m_n  = '0;
                            n_n  = '0;
                            k_n  = '0;
                        end else begin
                            state_n = IDLE;
                        end
                    end else begin
                        load = 1'b1;
                        if (out_step_k == KW'(K_STEPS - 1)) begin
                            k_n = '0;
                            if (out_step_n == NW'(N_STEPS - 1)) begin
                                n_n = '0;
                                m_n = out_step_m + 1'b1;
                            end else begin
                                n_n = out_step_n + 1'b1;
                            end
                        end else begin
                            k_n = out_step_k + 1'b1;
                        end
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        rs1_n   = 5'(RA + int'(m_n) * K_STEPS + int'(k_n));
        rs2_n   = 5'(RB + int'(n_n) * K_STEPS + int'(k_n));
        rd_n    = 5'(RC + int'(m_n) * N_STEPS + int'(n_n));
        first_n = (m_n == '0) && (n_n == '0) && (k_n == '0);
        last_n  = (m_n == MW'(M_STEPS - 1)) &&
                  (n_n == NW'(N_STEPS - 1)) &&
                  (k_n == KW'(K_STEPS - 1));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            out_wid    <= '0;
            out_fmt_s  <= '0;
            out_fmt_d  <= '0;
            out_tag    <= '0;
            out_step_m <= '0;
            out_step_n <= '0;
            out_step_k <= '0;
            out_rs1    <= '0;
            out_rs2    <= '0;
            out_rd     <= '0;
            out_first  <= 1'b0;
            out_last   <= 1'b0;
        end else begin
            state_q <= state_n;
            if (cap) begin
                out_wid   <= in_wid;
                out_fmt_s <= in_fmt_s;
                out_fmt_d <= in_fmt_d;
                out_tag   <= in_tag;
            end
            if (load) begin
                out_step_m <= m_n;
                out_step_n <= n_n;
                out_step_k <= k_n;
                out_rs1    <= rs1_n;
                out_rs2    <= rs2_n;
                out_rd     <= rd_n;
                out_first  <= first_n;
                out_last   <= last_n;
            end
        end
    end

`ifdef TCU_UOP_PERF_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            perf_instrs <= '0;
            perf_stalls <= '0;
        end else begin
            if (in_valid && in_ready) perf_instrs <= perf_instrs + 32'd1;
            if (out_valid && !out_ready) perf_stalls <= perf_stalls + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_tcu_uop_sequencer.sv
// Directed bench for tcu_uop_sequencer: default and 1x1x1 configurations.
module tb_tcu_uop_sequencer;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [1:0] in_wid = '0;
    logic [3:0] in_fmt_s = '0;
    logic [3:0] in_fmt_d = '0;
    logic [7:0] in_tag = '0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [1:0] out_wid;
    logic [3:0] out_fmt_s, out_fmt_d;
    logic [7:0] out_tag;
    logic [1:0] out_step_m;
    logic [0:0] out_step_n, out_step_k;
    logic [4:0] out_rs1, out_rs2, out_rd;
    logic       out_first, out_last, busy;
`ifdef TCU_UOP_PERF_EN
    logic [31:0] perf_instrs, perf_stalls;
    logic [31:0] d_perf_instrs, d_perf_stalls;
`endif

    logic       d_in_valid = 1'b0;
    logic       d_in_ready;
    logic       d_out_valid;
    logic [1:0] d_out_wid;
    logic [3:0] d_out_fmt_s, d_out_fmt_d;
    logic [7:0] d_out_tag;
    logic [0:0] d_step_m, d_step_n, d_step_k;
    logic [4:0] d_rs1, d_rs2, d_rd;
    logic       d_first, d_last, d_busy;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    tcu_uop_sequencer dut (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_wid(in_wid), .in_fmt_s(in_fmt_s),
        .in_fmt_d(in_fmt_d), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_wid(out_wid), .out_fmt_s(out_fmt_s),
        .out_fmt_d(out_fmt_d), .out_tag(out_tag),
        .out_step_m(out_step_m), .out_step_n(out_step_n),
        .out_step_k(out_step_k),
        .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
        .out_first(out_first), .out_last(out_last),
        .busy(busy)
`ifdef TCU_UOP_PERF_EN
        , .perf_instrs(perf_instrs), .perf_stalls(perf_stalls)
`endif
    );

    tcu_uop_sequencer #(.M_STEPS(1), .N_STEPS(1), .K_STEPS(1)) dut1 (
        .clk(clk), .reset_n(reset_n),
        .in_valid(d_in_valid), .in_ready(d_in_ready),
        .in_wid(in_wid), .in_fmt_s(in_fmt_s),
        .in_fmt_d(in_fmt_d), .in_tag(in_tag),
        .out_valid(d_out_valid), .out_ready(1'b1),
        .out_wid(d_out_wid), .out_fmt_s(d_out_fmt_s),
        .out_fmt_d(d_out_fmt_d), .out_tag(d_out_tag),
        .out_step_m(d_step_m), .out_step_n(d_step_n),
        .out_step_k(d_step_k),
        .out_rs1(d_rs1), .out_rs2(d_rs2), .out_rd(d_rd),
        .out_first(d_first), .out_last(d_last),
        .busy(d_busy)
`ifdef TCU_UOP_PERF_EN
        , .perf_instrs(d_perf_instrs), .perf_stalls(d_perf_stalls)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Check one uop of the default 4x2x2 configuration by flat index i
    task automatic chk_uop(input int i, input logic [7:0] tag);
        int m, n, k;
        m = i / 4;
        n = (i / 2) % 2;
        k = i % 2;
        chk($sformatf("valid[%0d]", i), 32'(out_valid), 32'd1);
        chk($sformatf("m[%0d]", i), 32'(out_step_m), 32'(m));
        chk($sformatf("n[%0d]", i), 32'(out_step_n), 32'(n));
        chk($sformatf("k[%0d]", i), 32'(out_step_k), 32'(k));
        chk($sformatf("rs1[%0d]", i), 32'(out_rs1), 32'(m * 2 + k));
        chk($sformatf("rs2[%0d]", i), 32'(out_rs2), 32'(28 + n * 2 + k));
        chk($sformatf("rd[%0d]", i), 32'(out_rd), 32'(10 + m * 2 + n));
        chk($sformatf("first[%0d]", i), 32'(out_first), 32'(i == 0));
        chk($sformatf("last[%0d]", i), 32'(out_last), 32'(i == 15));
        chk($sformatf("tag[%0d]", i), 32'(out_tag), 32'(tag));
    endtask

    initial begin
        #12;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ready", 32'(in_ready), 32'd1);
        chk("rst_rs2", 32'(out_rs2), 32'd0);
        chk("rst_first", 32'(out_first), 32'd0);
        reset_n = 1'b1;
        step();

        // Single instruction, i8 -> i32 formats echoed
        in_valid = 1'b1;
        in_tag = 8'h11;
        in_wid = 2'd1;
        in_fmt_s = 4'd9;
        in_fmt_d = 4'd8;
        step();
        in_valid = 1'b0;
        in_fmt_s = 4'd0;
        in_fmt_d = 4'd0;
        in_wid = 2'd0;
        for (int i = 0; i < 16; i++) begin
            chk_uop(i, 8'h11);
            chk($sformatf("fmt_s[%0d]", i), 32'(out_fmt_s), 32'd9);
            chk($sformatf("fmt_d[%0d]", i), 32'(out_fmt_d), 32'd8);
            chk($sformatf("wid[%0d]", i), 32'(out_wid), 32'd1);
            chk($sformatf("busy[%0d]", i), 32'(busy), 32'd1);
            chk($sformatf("in_ready[%0d]", i), 32'(in_ready), 32'(i == 15));
            step();
        end
        chk("end_busy", 32'(busy), 32'd0);
        chk("end_valid", 32'(out_valid), 32'd0);
        chk("end_ready", 32'(in_ready), 32'd1);

        // Back-to-back: second instruction held valid from uop0
        in_valid = 1'b1;
        in_tag = 8'h21;
        step();
        in_tag = 8'h22;
        for (int i = 0; i < 16; i++) begin
            chk_uop(i, 8'h21);
            chk($sformatf("b2b_ready[%0d]", i), 32'(in_ready), 32'(i == 15));
            step();
        end
        in_valid = 1'b0;

        // Second instruction with a 3-cycle stall on uop5
        for (int i = 0; i < 16; i++) begin
            chk_uop(i, 8'h22);
            if (i == 5) begin
                out_ready = 1'b0;
                for (int s = 0; s < 3; s++) begin
                    step();
                    chk($sformatf("stall_valid[%0d]", s), 32'(out_valid), 32'd1);
                    chk($sformatf("stall_rs1[%0d]", s), 32'(out_rs1), 32'd3);
                    chk($sformatf("stall_rs2[%0d]", s), 32'(out_rs2), 32'd29);
                    chk($sformatf("stall_rd[%0d]", s), 32'(out_rd), 32'd12);
                    chk($sformatf("stall_k[%0d]", s), 32'(out_step_k), 32'd1);
                end
                out_ready = 1'b1;
            end
            step();
        end
        chk("b2b_end_busy", 32'(busy), 32'd0);
`ifdef TCU_UOP_PERF_EN
        chk("perf_stalls", perf_stalls, 32'd3);
        chk("perf_instrs", perf_instrs, 32'd3);
`endif

        // Reset during uop7 drops the instruction
        in_valid = 1'b1;
        in_tag = 8'h33;
        step();
        in_valid = 1'b0;
        repeat (7) step();
        chk("pre_rst_rs1", 32'(out_rs1), 32'd3);
        chk("pre_rst_last", 32'(out_last), 32'd0);
        reset_n = 1'b0;
        #1;
        chk("async_valid", 32'(out_valid), 32'd0);
        chk("async_busy", 32'(busy), 32'd0);
        chk("async_rs1", 32'(out_rs1), 32'd0);
        chk("async_tag", 32'(out_tag), 32'd0);
        step();
        reset_n = 1'b1;
        step();
        chk("post_rst_valid", 32'(out_valid), 32'd0);
        in_valid = 1'b1;
        in_tag = 8'h44;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 16; i++) begin
            chk_uop(i, 8'h44);
            step();
        end
        chk("rst_end_busy", 32'(busy), 32'd0);

        // Degenerate 1x1x1 configuration
        chk("d_idle_ready", 32'(d_in_ready), 32'd1);
        d_in_valid = 1'b1;
        in_tag = 8'h55;
        step();
        d_in_valid = 1'b0;
        chk("d_valid", 32'(d_out_valid), 32'd1);
        chk("d_first", 32'(d_first), 32'd1);
        chk("d_last", 32'(d_last), 32'd1);
        chk("d_rs1", 32'(d_rs1), 32'd0);
        chk("d_rs2", 32'(d_rs2), 32'd28);
        chk("d_rd", 32'(d_rd), 32'd10);
        chk("d_tag", 32'(d_out_tag), 32'h55);
        chk("d_ready", 32'(d_in_ready), 32'd1);
        step();
        chk("d_done_valid", 32'(d_out_valid), 32'd0);
        chk("d_done_busy", 32'(d_busy), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
